fetch_controller: RTL and testbench

- Sequences the fetch stage of the 5-stage RV32I pipeline.
- Drives the program_counter stall/redirect inputs and runs a single-outstanding req/ready/rvalid handshake to instruction memory.
- Buffers one returned instruction while decode is stalled.
- Turns execute-stage redirects (PCSrcE/PCTargetE) into a clean PC update plus decode flush, including redirects that arrive while a fetch is in flight.

---
 rtl/fetch_controller.sv | 184 ++++++++++++++++++
 tb/tb_fetch_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// Fetch-stage sequencer for the RV32I pipeline: single-outstanding imem handshake,
// one-entry decode-stall buffer, redirect/flush handling. Optional perf counters: FETCH_PERF_CNT_EN.
module fetch_controller #(
  parameter int XLEN        = 32,
  parameter int BOOT_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic            StallD,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            imem_req,
  output logic            StallF,
  output logic            PCSrcF,
  output logic [XLEN-1:0] PCTargetF,
  output logic [XLEN-1:0] InstrF,
  output logic            InstrValidF,
  output logic            FlushD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     FetchCnt,
  output logic [31:0]     RedirCnt
`endif
);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_WAIT, S_HOLD} state_t;

  localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CW-1:0] BOOT_LAST = CW'((BOOT_CYCLES > 0) ? (BOOT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  // With no boot delay the first post-reset cycle must already be FETCH.
  localparam state_t RESET_STATE = (BOOT_CYCLES == 0) ? S_FETCH : S_BOOT;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_boot_cnt, w_boot_cnt_nxt;
  logic            r_pend, w_pend_nxt;
  logic [XLEN-1:0] r_pend_target, w_pend_target_nxt;
  logic [XLEN-1:0] r_buffer, w_buffer_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= RESET_STATE;
      r_boot_cnt    <= '0;
      r_pend        <= 1'b0;
      r_pend_target <= '0;
      r_buffer      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_boot_cnt    <= w_boot_cnt_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_target <= w_pend_target_nxt;
      r_buffer      <= w_buffer_nxt;
    end
  end

  always_comb begin
    imem_req          = 1'b0;
    StallF            = 1'b1;
    PCSrcF            = 1'b0;
    PCTargetF         = '0;
    InstrF            = '0;
    InstrValidF       = 1'b0;
    FlushD            = 1'b0;
    w_state_nxt       = r_state;
    w_boot_cnt_nxt    = r_boot_cnt;
    w_pend_nxt        = r_pend;
    w_pend_target_nxt = r_pend_target;
    w_buffer_nxt      = r_buffer;

    case (r_state)
      S_BOOT: begin
        FlushD = 1'b1;
        if (r_boot_cnt == BOOT_LAST) begin
          w_state_nxt    = S_FETCH;
          w_boot_cnt_nxt = '0;
        end else begin
          w_boot_cnt_nxt = r_boot_cnt + CNT_ONE;
        end
      end
      S_FETCH: begin
        if (PCSrcE) begin
          StallF    = 1'b0;
          PCSrcF    = 1'b1;
          PCTargetF = PCTargetE;
          FlushD    = 1'b1;
        end else begin
          imem_req = 1'b1;
          if (imem_ready) begin
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_FETCH;
          end
        end
      end
      S_WAIT: begin
        if (!imem_rvalid) begin
          // Remember the newest redirect; it is applied when the fetch returns.
          if (PCSrcE) begin
            w_pend_nxt        = 1'b1;
            w_pend_target_nxt = PCTargetE;
          end else begin
            w_pend_nxt = r_pend;
          end
        end else if (PCSrcE || r_pend) begin
          StallF      = 1'b0;
          PCSrcF      = 1'b1;
          PCTargetF   = PCSrcE ? PCTargetE : r_pend_target;
          FlushD      = 1'b1;
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_FETCH;
        end else if (!StallD) begin
          InstrValidF = 1'b1;
          InstrF      = imem_rdata;
          StallF      = 1'b0;
          w_state_nxt = S_FETCH;
        end else begin
          w_buffer_nxt = imem_rdata;
          w_state_nxt  = S_HOLD;
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          StallF      = 1'b0;
          PCSrcF      = 1'b1;
          PCTargetF   = PCTargetE;
          FlushD      = 1'b1;
          w_state_nxt = S_FETCH;
        end else begin
          InstrValidF = 1'b1;
          InstrF      = r_buffer;
          if (!StallD) begin
            StallF      = 1'b0;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_HOLD;
          end
        end
      end
      default: begin
        FlushD      = 1'b1;
        w_state_nxt = RESET_STATE;
      end
    endcase

    // Reset forces the idle/flush output pattern even when the reset state is FETCH.
    if (rst) begin
      imem_req    = 1'b0;
      StallF      = 1'b1;
      PCSrcF      = 1'b0;
      PCTargetF   = '0;
      InstrF      = '0;
      InstrValidF = 1'b0;
      FlushD      = 1'b1;
    end else begin
      FlushD = FlushD;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_redir_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
      r_redir_cnt <= 32'd0;
    end else begin
      if (InstrValidF && !StallD) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (PCSrcF) begin
        r_redir_cnt <= r_redir_cnt + 32'd1;
      end
    end
  end

  assign FetchCnt = r_fetch_cnt;
  assign RedirCnt = r_redir_cnt;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed vector table, async-reset sequence and
// randomized traffic checked against a transaction-level reference model.
module tb_fetch_controller;
  localparam int XLEN = 32;
  localparam int BOOT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, PCSrcE, StallD, imem_ready, imem_rvalid;
  logic [XLEN-1:0] PCTargetE, imem_rdata;
  logic imem_req, StallF, PCSrcF, InstrValidF, FlushD;
  logic [XLEN-1:0] PCTargetF, InstrF;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] FetchCnt, RedirCnt;
`endif

  fetch_controller #(.XLEN(XLEN), .BOOT_CYCLES(BOOT)) dut (
    .clk(clk), .rst(rst), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .StallD(StallD),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .imem_req(imem_req), .StallF(StallF), .PCSrcF(PCSrcF), .PCTargetF(PCTargetF),
    .InstrF(InstrF), .InstrValidF(InstrValidF), .FlushD(FlushD)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCnt(FetchCnt), .RedirCnt(RedirCnt)
`endif
  );

  typedef struct {
    logic rst, pce; logic [31:0] tgt; logic sd, rdy, rv; logic [31:0] rd;
    logic req, sf, psf; logic [31:0] tgtf; logic v; logic [31:0] instr; logic fl, chk;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: transaction view of the fetch stage.
  int          m_boot_left;
  bit          m_inflight, m_held, m_pend;
  logic [31:0] m_held_data, m_pend_tgt;
  logic [31:0] m_fetch_cnt, m_redir_cnt;
  logic        e_req, e_sf, e_psf, e_v, e_fl, e_chk;
  logic [31:0] e_tgt, e_instr;

  function automatic vec_t V(logic r, logic pce, logic [31:0] tgt, logic sd, logic rdy, logic rv,
                             logic [31:0] rd, logic req, logic sf, logic psf, logic [31:0] tgtf,
                             logic v, logic [31:0] instr, logic fl, logic chk);
    vec_t x;
    x.rst = r; x.pce = pce; x.tgt = tgt; x.sd = sd; x.rdy = rdy; x.rv = rv; x.rd = rd;
    x.req = req; x.sf = sf; x.psf = psf; x.tgtf = tgtf; x.v = v; x.instr = instr;
    x.fl = fl; x.chk = chk;
    return x;
  endfunction

  function automatic logic [71:0] pack(logic req, logic sf, logic psf, logic v, logic fl,
                                       logic [31:0] tgtf, logic [31:0] instr);
    return {req, sf, psf, v, fl, 3'b000, tgtf, instr};
  endfunction

  function automatic logic [71:0] dut_out(logic chk);
    return pack(imem_req, StallF, PCSrcF, InstrValidF, FlushD, PCTargetF, chk ? InstrF : 32'h0);
  endfunction

  task automatic check(string nm, logic [71:0] act, logic [71:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h (req,sf,psf,v,fl|tgt|instr)", nm, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_boot_left = BOOT; m_inflight = 0; m_held = 0; m_pend = 0;
    m_held_data = 32'h0; m_pend_tgt = 32'h0; m_fetch_cnt = 32'h0; m_redir_cnt = 32'h0;
  endtask

  task automatic redirect_to(logic [31:0] t);
    e_fl = 1'b1; e_sf = 1'b0; e_psf = 1'b1; e_tgt = t;
  endtask

  task automatic model_eval();
    e_req = 0; e_sf = 1; e_psf = 0; e_tgt = 32'h0; e_v = 0; e_instr = 32'h0; e_fl = 0; e_chk = 0;
    if (rst || m_boot_left > 0) begin
      e_fl = 1'b1; e_chk = 1'b1;
    end else if (m_held) begin
      if (PCSrcE) redirect_to(PCTargetE);
      else begin
        e_v = 1'b1; e_instr = m_held_data; e_chk = 1'b1;
        if (!StallD) e_sf = 1'b0;
      end
    end else if (m_inflight) begin
      if (imem_rvalid) begin
        if (PCSrcE) redirect_to(PCTargetE);
        else if (m_pend) redirect_to(m_pend_tgt);
        else if (!StallD) begin
          e_v = 1'b1; e_instr = imem_rdata; e_chk = 1'b1; e_sf = 1'b0;
        end
      end
    end else begin
      if (PCSrcE) redirect_to(PCTargetE);
      else e_req = 1'b1;
    end
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
    end else begin
      if (e_v && !StallD) m_fetch_cnt++;
      if (e_psf) m_redir_cnt++;
      if (m_boot_left > 0) m_boot_left--;
      else if (m_held) begin
        if (PCSrcE || !StallD) m_held = 0;
      end else if (m_inflight) begin
        if (imem_rvalid) begin
          if (!(PCSrcE || m_pend) && StallD) begin
            m_held = 1; m_held_data = imem_rdata;
          end
          m_inflight = 0; m_pend = 0;
        end else if (PCSrcE) begin
          m_pend = 1; m_pend_tgt = PCTargetE;
        end
      end else if (!PCSrcE && imem_ready) m_inflight = 1;
    end
  endtask

  // One clock: inputs already applied, compare mid-cycle, advance model at the edge.
  task automatic cycle(string nm, bit vs_model);
    #3;
    model_eval();
    if (vs_model) check(nm, dut_out(e_chk), pack(e_req, e_sf, e_psf, e_v, e_fl, e_tgt, e_instr));
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive(logic r, logic pce, logic [31:0] tgt, logic sd, logic rdy, logic rv, logic [31:0] rd);
    rst = r; PCSrcE = pce; PCTargetE = tgt; StallD = sd; imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
  endtask

  vec_t tbl[$];

  initial begin
    model_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);

    // rst pce tgt sd rdy rv rdata | req sf psf tgtf v instr fl chk
    tbl.push_back(V(1,0,32'd0 ,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,1,1));
    tbl.push_back(V(1,0,32'd0 ,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,1,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,1,1));
    tbl.push_back(V(0,1,32'd64,0,1,1,32'hDEAD0001, 0,1,0,32'd0 ,0,32'h0       ,1,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,1,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,1,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,0,1,1,32'h00500093, 0,0,0,32'd0 ,1,32'h00500093,0,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,1,1,1,32'h00A00113, 0,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,1,1,0,32'h0       , 0,1,0,32'd0 ,1,32'h00A00113,0,1));
    tbl.push_back(V(0,0,32'd0 ,1,1,0,32'h0       , 0,1,0,32'd0 ,1,32'h00A00113,0,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 0,0,0,32'd0 ,1,32'h00A00113,0,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,1,32'd20,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,0,1,1,32'hDEADBEEF, 0,0,1,32'd20,0,32'h0       ,1,0));
    tbl.push_back(V(0,0,32'd0 ,0,0,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,1,32'd20,0,1,0,32'h0       , 0,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,1,32'd30,0,1,1,32'hCAFEF00D, 0,0,1,32'd30,0,32'h0       ,1,0));
    tbl.push_back(V(0,1,32'd40,0,1,0,32'h0       , 0,0,1,32'd40,0,32'h0       ,1,0));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,0,1,1,32'h11111111, 0,0,0,32'd0 ,1,32'h11111111,0,1));
    tbl.push_back(V(0,0,32'd0 ,0,1,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,0,32'd0 ,1,1,1,32'h22222222, 0,1,0,32'd0 ,0,32'h0       ,0,0));
    tbl.push_back(V(0,1,32'd80,1,1,0,32'h0       , 0,0,1,32'd80,0,32'h0       ,1,0));
    tbl.push_back(V(0,0,32'd0 ,0,0,0,32'h0       , 1,1,0,32'd0 ,0,32'h0       ,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].pce, tbl[i].tgt, tbl[i].sd, tbl[i].rdy, tbl[i].rv, tbl[i].rd);
      #3;
      check($sformatf("table[%0d]", i), dut_out(tbl[i].chk),
            pack(tbl[i].req, tbl[i].sf, tbl[i].psf, tbl[i].v, tbl[i].fl, tbl[i].tgtf, tbl[i].instr));
      model_eval();
      @(posedge clk);
      model_update();
      #1;
    end

    // Reach HOLD, then assert reset between edges: outputs must fall back at once.
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);           cycle("hold_fetch", 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h33333333);   cycle("hold_fill", 1'b1);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0);           cycle("hold_stay", 1'b1);
    rst = 1'b1;
    #1;
    check("async_rst_in_hold", dut_out(1'b1), pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0));
    model_reset();
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h44444444);   cycle("rst_stray_rvalid", 1'b1);
    for (int i = 0; i < BOOT + 3; i++) begin
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 32'h55555555);
      cycle($sformatf("boot_stray_rvalid[%0d]", i), 1'b1);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0), $urandom,
            ($urandom_range(0, 2) == 0), ($urandom_range(0, 1) == 1),
            ($urandom_range(0, 2) == 0), $urandom);
      cycle("random", 1'b1);
    end

`ifdef FETCH_PERF_CNT_EN
    check("fetch_cnt", {40'h0, FetchCnt}, {40'h0, m_fetch_cnt});
    check("redir_cnt", {40'h0, RedirCnt}, {40'h0, m_redir_cnt});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
